// File: rtl/hazard3_cmp_arbiter.sv
// Two-requester arbiter in front of one branch-style comparator, with a one-entry result buffer.
// Define HAZARD3_CMP_ARBITER_FAIRNESS_EN to add the req1 anti-starvation counter.
module hazard3_cmp_arbiter #(
    parameter int W_DATA     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [W_DATA-1:0] req0_a,
    input  logic [W_DATA-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [W_DATA-1:0] req1_a,
    input  logic [W_DATA-1:0] req1_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic              resp_result,
    output logic              resp_illegal
);

    logic buf_vld_q, buf_vld_d;
    logic buf_owner_q, buf_owner_d;
    logic buf_result_q, buf_result_d;
    logic buf_illegal_q, buf_illegal_d;

    logic              accept;
    logic              force1;
    logic              grant1;
    logic              take0;
    logic              take1;
    logic [2:0]        op_sel;
    logic [W_DATA-1:0] a_sel;
    logic [W_DATA-1:0] b_sel;
    logic [W_DATA-1:0] diff;
    logic              lt;
    logic              eq;
    logic              illegal;
    logic              result;

`ifdef HAZARD3_CMP_ARBITER_FAIRNESS_EN
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_ctr_q, starve_ctr_d;

    assign force1 = req1_valid && (starve_ctr_q == SW'(STARVE_MAX));
`else
    assign force1 = 1'b0;
`endif

    // Buffer frees and refills in the same cycle when its owner consumes.
    always_comb begin
        accept     = !rst && (!buf_vld_q || (buf_owner_q ? resp1_ready : resp0_ready));
        grant1     = force1 || (!req0_valid && req1_valid);
        req0_ready = accept && !grant1;
        req1_ready = accept && grant1;
        take0      = req0_ready && req0_valid;
        take1      = req1_ready;
    end

    always_comb begin
        op_sel  = grant1 ? req1_op : req0_op;
        a_sel   = grant1 ? req1_a : req0_a;
        b_sel   = grant1 ? req1_b : req0_b;
        diff    = a_sel - b_sel;
        eq      = (a_sel == b_sel);
        // Differing sign bits decide the order without the subtractor.
        if (a_sel[W_DATA-1] == b_sel[W_DATA-1]) begin
            lt = diff[W_DATA-1];
        end else begin
            lt = op_sel[1] ? b_sel[W_DATA-1] : a_sel[W_DATA-1];
        end
        illegal = (op_sel[2:1] == 2'b01);
        if (illegal) begin
            result = 1'b0;
        end else begin
            result = op_sel[2] ? (lt ^ op_sel[0]) : (eq ^ op_sel[0]);
        end
    end

    always_comb begin
        buf_vld_d     = buf_vld_q;
        buf_owner_d   = buf_owner_q;
        buf_result_d  = buf_result_q;
        buf_illegal_d = buf_illegal_q;
        if (accept) begin
            buf_vld_d = take0 || take1;
            if (take0 || take1) begin
                buf_owner_d   = take1;
                buf_result_d  = result;
                buf_illegal_d = illegal;
            end
        end
    end

`ifdef HAZARD3_CMP_ARBITER_FAIRNESS_EN
    always_comb begin
        starve_ctr_d = starve_ctr_q;
        if (!req1_valid || req1_ready) begin
            starve_ctr_d = '0;
        end else if (accept && (starve_ctr_q != SW'(STARVE_MAX))) begin
            starve_ctr_d = starve_ctr_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_ctr_q <= '0;
        end else begin
            starve_ctr_q <= starve_ctr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q     <= 1'b0;
            buf_owner_q   <= 1'b0;
            buf_result_q  <= 1'b0;
            buf_illegal_q <= 1'b0;
        end else begin
            buf_vld_q     <= buf_vld_d;
            buf_owner_q   <= buf_owner_d;
            buf_result_q  <= buf_result_d;
            buf_illegal_q <= buf_illegal_d;
        end
    end

    // Reset also masks the held response so a discarded result is never presented.
    assign resp0_valid  = buf_vld_q && !buf_owner_q && !rst;
    assign resp1_valid  = buf_vld_q && buf_owner_q && !rst;
    assign resp_result  = buf_result_q;
    assign resp_illegal = buf_illegal_q;

endmodule

// File: tb/tb_hazard3_cmp_arbiter.sv
// Scoreboard bench for hazard3_cmp_arbiter: accepted requests push hand-computed results,
// a negedge monitor pops and compares them against the response handshake.
module tb_hazard3_cmp_arbiter;

    localparam int W = 32;
    localparam int SMAX = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic         resp_result, resp_illegal;

    // Expected result for whatever each requester is currently driving.
    logic exp0_r, exp0_i, exp1_r, exp1_i;

    typedef struct {
        logic owner;
        logic result;
        logic illegal;
        int   cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic rst_prev = 1'b0;

    hazard3_cmp_arbiter #(.W_DATA(W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_illegal(resp_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // Monitor: pops before pushing so a same-cycle free/refill keeps queue order.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            check("reset_handshakes", {req0_ready, req1_ready, resp0_valid, resp1_valid}, 4'b0);
            if (rst_prev) check("reset_result", {resp_result, resp_illegal}, 2'b00);
        end else begin
            check("ready_onehot", {31'b0, req0_ready && req1_ready}, 32'd0);
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("resp_valid", {resp1_valid, resp0_valid},
                      sb[0].owner ? 2'b10 : 2'b01);
                check("resp_result", resp_result, sb[0].result);
                check("resp_illegal", resp_illegal, sb[0].illegal);
                if (sb[0].owner ? resp1_ready : resp0_ready) begin
                    $display("resp owner=%0d result=%0d illegal=%0d cyc=%0d",
                             sb[0].owner, resp_result, resp_illegal, cyc);
                    void'(sb.pop_front());
                end
            end else if (sb.size() == 0) begin
                check("resp_idle", {resp1_valid, resp0_valid}, 2'b00);
            end
            if (req0_valid && req0_ready) sb.push_back('{1'b0, exp0_r, exp0_i, cyc});
            if (req1_valid && req1_ready) sb.push_back('{1'b1, exp1_r, exp1_i, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic r, input logic i);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; exp0_r = r; exp0_i = i;
    endtask

    task automatic drive1(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic r, input logic i);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; exp1_r = r; exp1_i = i;
    endtask

    logic [2:0] ops [8];
    logic       op_res [8];
    logic       op_ill [8];
    logic       want1;

    initial begin
        ops    = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
        op_res = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        op_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        drive0(1'b1, 3'b000, 32'd0, 32'd0, 1'b1, 1'b0);
        drive1(1'b1, 3'b000, 32'd4, 32'd4, 1'b1, 1'b0);

        // Reset held two cycles with both requests valid.
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_req0_ready", {req0_ready, req1_ready}, 2'b10);
        #1;
        drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);

        // Every op on a=-1, b=1, back to back.
        for (int k = 0; k < 8; k++) begin
            step();
            drive0(1'b1, ops[k], 32'hFFFF_FFFF, 32'd1, op_res[k], op_ill[k]);
        end
        step();
        drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();

        // Contention with the buffer empty.
        drive0(1'b1, 3'b101, 32'hFFFF_FFFB, 32'd3, 1'b0, 1'b0);
        drive1(1'b1, 3'b000, 32'd5, 32'd5, 1'b1, 1'b0);
        @(negedge clk);
        check("contend_ready", {req0_ready, req1_ready}, 2'b10);
        step();
        drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("contend_resp0", resp0_valid, 1'b1);
        check("held_req1_ready", req1_ready, 1'b1);
        step();
        drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();

        // Backpressure on resp0 for four cycles, then release.
        resp0_ready = 1'b0;
        drive0(1'b1, 3'b100, 32'd2, 32'd9, 1'b1, 1'b0);
        step();
        drive0(1'b1, 3'b001, 32'd7, 32'd7, 1'b0, 1'b0);
        drive1(1'b1, 3'b110, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_ready", {req0_ready, req1_ready}, 2'b00);
            step();
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        check("release_refill", req0_ready, 1'b1);
        step();
        drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();

        // Continuous contention: grant pattern depends on the fairness build.
        drive0(1'b1, 3'b000, 32'd10, 32'd10, 1'b1, 1'b0);
        drive1(1'b1, 3'b111, 32'd10, 32'd11, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
`ifdef HAZARD3_CMP_ARBITER_FAIRNESS_EN
            want1 = ((k % (SMAX + 1)) == SMAX);
`else
            want1 = 1'b0;
`endif
            check("grant_seq", {req0_ready, req1_ready}, want1 ? 2'b01 : 2'b10);
            step();
        end
        drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();

        // Accept req1, then reset before its response can be observed.
        drive1(1'b1, 3'b000, 32'd3, 32'd3, 1'b1, 1'b0);
        @(negedge clk);
        check("midrst_accept", req1_ready, 1'b1);
        step();
        rst = 1'b1;
        drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_resp", resp1_valid, 1'b0);
            step();
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

endmodule
